// File: rtl/video_timing_pkg.sv
// video_timing_pkg: standard raster mode constants and total-length helper
package video_timing_pkg;
  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam bit VGA_H_POL = 1'b0;
  localparam bit VGA_V_POL = 1'b0;
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP = 40;
  localparam int SVGA_H_SYNC = 128;
  localparam int SVGA_H_BP = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP = 1;
  localparam int SVGA_V_SYNC = 4;
  localparam int SVGA_V_BP = 23;
  localparam bit SVGA_H_POL = 1'b1;
  localparam bit SVGA_V_POL = 1'b1;
  localparam int HD_H_ACTIVE = 1280;
  localparam int HD_H_FP = 110;
  localparam int HD_H_SYNC = 40;
  localparam int HD_H_BP = 220;
  localparam int HD_V_ACTIVE = 720;
  localparam int HD_V_FP = 5;
  localparam int HD_V_SYNC = 5;
  localparam int HD_V_BP = 20;
  localparam bit HD_H_POL = 1'b1;
  localparam bit HD_V_POL = 1'b1;
endpackage

// File: rtl/video_timing_gen_axis.sv
// timing_axis: one wrapping raster counter with registered position, active and sync decodes
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int LEN_ACTIVE = 640,
  parameter int LEN_FP = 16,
  parameter int LEN_SYNC = 96,
  parameter int LEN_BP = 48,
  parameter bit POL = 1'b0,
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  input  logic          ld,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic [CW-1:0] pos,
  output logic          active,
  output logic          sync
);
  localparam logic [CW-1:0] LAST = CW'(timing_total(LEN_ACTIVE, LEN_FP, LEN_SYNC, LEN_BP) - 1);
  localparam logic [CW-1:0] ACT_END = CW'(LEN_ACTIVE);
  localparam logic [CW-1:0] SYNC_LO = CW'(LEN_ACTIVE + LEN_FP);
  localparam logic [CW-1:0] SYNC_HI = CW'(LEN_ACTIVE + LEN_FP + LEN_SYNC);
  assign wrap = cnt == LAST;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (adv) cnt <= wrap ? '0 : cnt + 1'b1;
  always_ff @(posedge clk)
    if (rst) begin
      pos <= '0;
      active <= 1'b0;
      sync <= ~POL;
    end else if (ld) begin
      pos <= cnt;
      active <= cnt < ACT_END;
      sync <= (cnt >= SYNC_LO && cnt < SYNC_HI) ? POL : ~POL;
    end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator with enable, resync and aligned outputs
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CW = 12,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter bit H_POL = VGA_H_POL,
  parameter bit V_POL = VGA_V_POL
) (
  input  logic          pixclk,
  input  logic          reset,
  input  logic          en,
  input  logic          resync,
  output logic [CW-1:0] CounterX,
  output logic [CW-1:0] CounterY,
  output logic          hSync,
  output logic          vSync,
  output logic          DrawArea,
  output logic          line_start,
  output logic          frame_start,
  output logic          animate
);
  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  if (H_TOTAL > 2 ** CW || V_TOTAL > 2 ** CW) begin : g_cw_check
    $error("video_timing_gen: CW=%0d too narrow for %0dx%0d total raster", CW, H_TOTAL, V_TOTAL);
  end
  logic [CW-1:0] hx, vy;
  logic h_wrap, h_de, v_de;
  timing_axis #(
    .LEN_ACTIVE(H_ACTIVE), .LEN_FP(H_FP), .LEN_SYNC(H_SYNC), .LEN_BP(H_BP), .POL(H_POL), .CW(CW)
  ) u_h (
    .clk(pixclk), .rst(reset), .clr(resync), .adv(en), .ld(en),
    .cnt(hx), .wrap(h_wrap), .pos(CounterX), .active(h_de), .sync(hSync)
  );
  timing_axis #(
    .LEN_ACTIVE(V_ACTIVE), .LEN_FP(V_FP), .LEN_SYNC(V_SYNC), .LEN_BP(V_BP), .POL(V_POL), .CW(CW)
  ) u_v (
    .clk(pixclk), .rst(reset), .clr(resync), .adv(en && h_wrap), .ld(en),
    .cnt(vy), .wrap(), .pos(CounterY), .active(v_de), .sync(vSync)
  );
  assign DrawArea = h_de && v_de;
  always_ff @(posedge pixclk)
    if (reset) begin
      line_start <= 1'b0;
      frame_start <= 1'b0;
      animate <= 1'b0;
    end else if (en) begin
      line_start <= hx == '0;
      frame_start <= hx == '0 && vy == '0;
      animate <= hx == CW'(H_ACTIVE) && vy == CW'(V_ACTIVE);
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: table, aggregate and randomized model checks on two small raster modes
module tb_video_timing_gen;
  typedef struct packed {
    int ha, hf, hsw, hb, va, vf, vsw, vb;
    bit hp, vp;
  } mode_t;
  typedef struct {
    bit r, e, s;
    logic [21:0] exp;
  } vec_t;
  localparam mode_t MA = '{16, 2, 4, 3, 6, 1, 2, 2, 1'b0, 1'b0};
  localparam mode_t MB = '{20, 3, 5, 4, 5, 2, 1, 3, 1'b1, 1'b1};
  logic pixclk = 1'b0, reset = 1'b1, en = 1'b0, resync = 1'b0;
  logic [7:0] xa, ya, xb, yb;
  logic hsa, vsa, dea, lsa, fsa, ana, hsb, vsb, deb, lsb, fsb, anb;
  logic [21:0] got_a, got_b;
  int checks = 0, errors = 0;
  int a_nxt = 0, a_disp = -1, b_nxt = 0, b_disp = -1;
  mode_t md[2];
  logic [21:0] g[2];
  vec_t tbl[8];
  int fs_prev[2], fs_per[2], de_cnt[2], de_frame[2], hs_cnt[2], hs_line[2];
  int vs_cnt[2], vs_frame[2], hs_x[2], vs_x[2], vs_y[2], an_x[2], an_y[2];
  always #5 pixclk = ~pixclk;
  video_timing_gen #(
    .CW(8), .H_ACTIVE(MA.ha), .H_FP(MA.hf), .H_SYNC(MA.hsw), .H_BP(MA.hb),
    .V_ACTIVE(MA.va), .V_FP(MA.vf), .V_SYNC(MA.vsw), .V_BP(MA.vb), .H_POL(MA.hp), .V_POL(MA.vp)
  ) dut_a (
    .pixclk(pixclk), .reset(reset), .en(en), .resync(resync),
    .CounterX(xa), .CounterY(ya), .hSync(hsa), .vSync(vsa), .DrawArea(dea),
    .line_start(lsa), .frame_start(fsa), .animate(ana)
  );
  video_timing_gen #(
    .CW(8), .H_ACTIVE(MB.ha), .H_FP(MB.hf), .H_SYNC(MB.hsw), .H_BP(MB.hb),
    .V_ACTIVE(MB.va), .V_FP(MB.vf), .V_SYNC(MB.vsw), .V_BP(MB.vb), .H_POL(MB.hp), .V_POL(MB.vp)
  ) dut_b (
    .pixclk(pixclk), .reset(reset), .en(en), .resync(resync),
    .CounterX(xb), .CounterY(yb), .hSync(hsb), .vSync(vsb), .DrawArea(deb),
    .line_start(lsb), .frame_start(fsb), .animate(anb)
  );
  assign got_a = {xa, ya, hsa, vsa, dea, lsa, fsa, ana};
  assign got_b = {xb, yb, hsb, vsb, deb, lsb, fsb, anb};
  function automatic int h_total(mode_t m);
    return m.ha + m.hf + m.hsw + m.hb;
  endfunction
  function automatic int f_total(mode_t m);
    return h_total(m) * (m.va + m.vf + m.vsw + m.vb);
  endfunction
  function automatic logic [21:0] expect_vec(mode_t m, int d);
    int x, y, hs0, vs0;
    logic hs, vs;
    if (d < 0) return {16'd0, ~m.hp, ~m.vp, 4'd0};
    x = d % h_total(m);
    y = d / h_total(m);
    hs0 = m.ha + m.hf;
    vs0 = m.va + m.vf;
    hs = (x >= hs0 && x < hs0 + m.hsw) ? m.hp : ~m.hp;
    vs = (y >= vs0 && y < vs0 + m.vsw) ? m.vp : ~m.vp;
    return {8'(x), 8'(y), hs, vs, x < m.ha && y < m.va, x == 0, x == 0 && y == 0, x == m.ha && y == m.va};
  endfunction
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic model_upd(bit r, bit e, bit s, inout int nxt, inout int disp, input int ft);
    if (r) begin
      nxt = 0;
      disp = -1;
    end else if (s) begin
      if (e) disp = nxt;
      nxt = 0;
    end else if (e) begin
      disp = nxt;
      nxt = (nxt + 1) % ft;
    end
  endtask
  task automatic step(bit r, bit e, bit s);
    reset = r;
    en = e;
    resync = s;
    @(posedge pixclk);
    model_upd(r, e, s, a_nxt, a_disp, f_total(MA));
    model_upd(r, e, s, b_nxt, b_disp, f_total(MB));
    #1;
    chk("model_a", 32'(got_a), 32'(expect_vec(MA, a_disp)));
    chk("model_b", 32'(got_b), 32'(expect_vec(MB, b_disp)));
  endtask
  initial begin
    md[0] = MA;
    md[1] = MB;
    tbl[0] = '{1'b1, 1'b0, 1'b0, {8'd0, 8'd0, 2'b11, 4'b0000}};
    tbl[1] = '{1'b0, 1'b1, 1'b0, {8'd0, 8'd0, 2'b11, 4'b1110}};
    tbl[2] = '{1'b0, 1'b1, 1'b0, {8'd1, 8'd0, 2'b11, 4'b1000}};
    tbl[3] = '{1'b0, 1'b0, 1'b0, {8'd1, 8'd0, 2'b11, 4'b1000}};
    tbl[4] = '{1'b0, 1'b1, 1'b0, {8'd2, 8'd0, 2'b11, 4'b1000}};
    tbl[5] = '{1'b0, 1'b1, 1'b1, {8'd3, 8'd0, 2'b11, 4'b1000}};
    tbl[6] = '{1'b0, 1'b1, 1'b0, {8'd0, 8'd0, 2'b11, 4'b1110}};
    tbl[7] = '{1'b1, 1'b1, 1'b1, {8'd0, 8'd0, 2'b11, 4'b0000}};
    repeat (3) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].s);
      chk($sformatf("table_%0d", i), 32'(got_a), 32'(tbl[i].exp));
    end
    for (int k = 0; k < 2; k++) begin
      fs_prev[k] = -1; fs_per[k] = 0; de_cnt[k] = 0; de_frame[k] = 0; hs_cnt[k] = 0;
      hs_line[k] = 0; vs_cnt[k] = 0; vs_frame[k] = 0; hs_x[k] = -1; vs_x[k] = -1;
      vs_y[k] = -1; an_x[k] = -1; an_y[k] = -1;
    end
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 720; i++) begin
      step(1'b0, 1'b1, 1'b0);
      g[0] = got_a;
      g[1] = got_b;
      for (int k = 0; k < 2; k++) begin
        if (g[k][1]) begin
          if (fs_prev[k] >= 0) begin
            fs_per[k] = i - fs_prev[k];
            de_frame[k] = de_cnt[k];
            vs_frame[k] = vs_cnt[k];
          end
          fs_prev[k] = i;
          de_cnt[k] = 0;
          vs_cnt[k] = 0;
        end
        if (g[k][2]) begin
          hs_line[k] = hs_cnt[k];
          hs_cnt[k] = 0;
        end
        de_cnt[k] += int'(g[k][3]);
        if (g[k][5] == md[k].hp) begin
          hs_cnt[k]++;
          if (hs_x[k] < 0) hs_x[k] = int'(g[k][21:14]);
        end
        if (g[k][4] == md[k].vp) begin
          vs_cnt[k]++;
          if (vs_y[k] < 0) begin
            vs_y[k] = int'(g[k][13:6]);
            vs_x[k] = int'(g[k][21:14]);
          end
        end
        if (g[k][0]) begin
          an_x[k] = int'(g[k][21:14]);
          an_y[k] = int'(g[k][13:6]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("frame_period_%0d", k), 32'(fs_per[k]), 32'(f_total(md[k])));
      chk($sformatf("de_per_frame_%0d", k), 32'(de_frame[k]), 32'(md[k].ha * md[k].va));
      chk($sformatf("hsync_width_%0d", k), 32'(hs_line[k]), 32'(md[k].hsw));
      chk($sformatf("hsync_start_x_%0d", k), 32'(hs_x[k]), 32'(md[k].ha + md[k].hf));
      chk($sformatf("vsync_cycles_%0d", k), 32'(vs_frame[k]), 32'(md[k].vsw * h_total(md[k])));
      chk($sformatf("vsync_start_y_%0d", k), 32'(vs_y[k]), 32'(md[k].va + md[k].vf));
      chk($sformatf("vsync_start_x_%0d", k), 32'(vs_x[k]), 32'd0);
      chk($sformatf("animate_x_%0d", k), 32'(an_x[k]), 32'(md[k].ha));
      chk($sformatf("animate_y_%0d", k), 32'(an_y[k]), 32'(md[k].va));
    end
    step(1'b1, 1'b0, 1'b0);
    repeat (86) step(1'b0, 1'b1, 1'b0);
    chk("pre_resync_xy", {xa, ya}, {8'd10, 8'd3});
    step(1'b0, 1'b1, 1'b1);
    chk("resync_cycle_xy", {xa, ya}, {8'd11, 8'd3});
    step(1'b0, 1'b1, 1'b0);
    chk("post_resync_xy_fs", {xa, ya, fsa}, {8'd0, 8'd0, 1'b1});
    step(1'b1, 1'b0, 1'b0);
    repeat (181) step(1'b0, 1'b1, 1'b0);
    chk("mid_vsync_a", {xa, ya, vsa}, {8'd5, 8'd7, 1'b0});
    step(1'b1, 1'b1, 1'b0);
    chk("reset_sync_a", {hsa, vsa}, 2'b11);
    chk("reset_sync_b", {hsb, vsb}, 2'b00);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(499) == 0, 1'($urandom), $urandom_range(199) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
